// File: rtl/vlt_pkg.sv
// Shared opcodes, shift-pair and class types for the store-queue vulnerability accumulator.
package vlt_pkg;

  localparam int OP_SB    = 6;
  localparam int OP_SH    = 7;
  localparam int OP_SW    = 8;
  localparam int OP_SD    = 10;
  localparam int OP_SWL   = 15;
  localparam int OP_SWR   = 16;
  localparam int OP_SDL   = 17;
  localparam int OP_SDR   = 18;
  localparam int OP_SC_0  = 21;
  localparam int OP_SCD_0 = 23;

  localparam int N_CLS = 4;

  typedef struct packed {
    logic [2:0] s1;
    logic [2:0] s2;
    logic       valid;
  } vlt_shift_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_72   = 3'd1,
    CLS_80   = 3'd2,
    CLS_96   = 3'd3,
    CLS_144  = 3'd4
  } vlt_cls_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REPORT = 1'b1
  } vlt_state_e;

  // Class index k (0..3) in class_cnt_o corresponds to enum value k+1.
  function automatic vlt_cls_e pair_to_cls(input vlt_shift_t p);
    vlt_cls_e c;
    c = CLS_NONE;
    if (p.valid) begin
      case ({p.s1, p.s2})
        6'b110_011: c = CLS_72;
        6'b110_100: c = CLS_80;
        6'b110_101: c = CLS_96;
        6'b111_100: c = CLS_144;
        default:    c = CLS_NONE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/vlt_sq_weight.sv
// Per-port combinational decode: opcode/importance to ACE shift pair and class,
// plus residency duration modulo 2^TS_W.
module vlt_sq_weight
  import vlt_pkg::*;
#(
  parameter int OPC_W = 9,
  parameter int TS_W  = 10
) (
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             important_i,
  input  logic [TS_W-1:0]  start_ts_i,
  input  logic [TS_W-1:0]  end_ts_i,
  output vlt_shift_t       shift_o,
  output vlt_cls_e         cls_o,
  output logic [TS_W-1:0]  dur_o
);

  logic grp_word;
  logic grp_byte;
  logic grp_dbl;

  always_comb begin
    grp_word = 1'b0;
    grp_byte = 1'b0;
    grp_dbl  = 1'b0;
    case (opcode_i)
      OPC_W'(OP_SW), OPC_W'(OP_SH), OPC_W'(OP_SWL), OPC_W'(OP_SWR): grp_word = 1'b1;
      OPC_W'(OP_SB): grp_byte = 1'b1;
      OPC_W'(OP_SD), OPC_W'(OP_SDL), OPC_W'(OP_SDR), OPC_W'(OP_SC_0), OPC_W'(OP_SCD_0): grp_dbl = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    shift_o = '0;
    if (grp_word || grp_byte || grp_dbl) begin
      shift_o.valid = 1'b1;
      if (!important_i) begin
        shift_o.s1 = 3'd6;
        shift_o.s2 = 3'd3;
      end else if (grp_word) begin
        shift_o.s1 = 3'd6;
        shift_o.s2 = 3'd5;
      end else if (grp_byte) begin
        shift_o.s1 = 3'd6;
        shift_o.s2 = 3'd4;
      end else begin
        shift_o.s1 = 3'd7;
        shift_o.s2 = 3'd4;
      end
    end
  end

  assign cls_o = pair_to_cls(shift_o);
  assign dur_o = end_ts_i - start_ts_i;

endmodule

// File: rtl/vlt_sq_accum.sv
// Two-stage store-queue vulnerability accumulator with window snapshot.
// Optional per-class counters are built when VLT_SQ_CLASS_CNT_EN is defined.
module vlt_sq_accum
  import vlt_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int TS_W  = 10,
  parameter int OPC_W = 9,
  parameter int ACC_W = 48,
  parameter int CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [PORTS-1:0]       v_i,
  input  logic [PORTS-1:0]       important_i,
  input  logic [PORTS*OPC_W-1:0] opcode_i,
  input  logic [PORTS*TS_W-1:0]  start_ts_i,
  input  logic [PORTS*TS_W-1:0]  end_ts_i,
  input  logic                   dump_req_i,
  output logic                   dump_ready_o,
  output logic [ACC_W-1:0]       vul_o,
  output logic [CNT_W-1:0]       evt_cnt_o,
  output logic                   sat_o,
  output logic                   v_o,
  input  logic                   yumi_i,
  output logic [4*CNT_W-1:0]     class_cnt_o,
  output vlt_state_e             state_o
);

  localparam int CONTRIB_W = TS_W + 8;
  localparam int EC_W      = $clog2(PORTS) + 1;
  localparam int SUM_W     = CONTRIB_W + EC_W;
  localparam int ADD_W     = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam int CADD_W    = CNT_W + 1;

  vlt_shift_t       sh_w   [PORTS];
  vlt_cls_e         cls_w  [PORTS];
  logic [TS_W-1:0]  dur_w  [PORTS];

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    vlt_sq_weight #(.OPC_W(OPC_W), .TS_W(TS_W)) u_weight (
      .opcode_i    (opcode_i[p*OPC_W +: OPC_W]),
      .important_i (important_i[p]),
      .start_ts_i  (start_ts_i[p*TS_W +: TS_W]),
      .end_ts_i    (end_ts_i[p*TS_W +: TS_W]),
      .shift_o     (sh_w[p]),
      .cls_o       (cls_w[p]),
      .dur_o       (dur_w[p])
    );
  end

  // Stage 1: per-port shift pair, class and duration, gated by the port valid.
  vlt_shift_t      sh1_d  [PORTS], sh1_q  [PORTS];
  vlt_cls_e        cls1_d [PORTS], cls1_q [PORTS];
  logic [TS_W-1:0] dur1_d [PORTS], dur1_q [PORTS];

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      sh1_d[p]       = sh_w[p];
      sh1_d[p].valid = sh_w[p].valid & v_i[p];
      cls1_d[p]      = v_i[p] ? cls_w[p] : CLS_NONE;
      dur1_d[p]      = dur_w[p];
    end
  end

  logic [SUM_W-1:0] sum2_d, sum2_q;
  logic [EC_W-1:0]  cnt2_d, cnt2_q;

  always_comb begin
    sum2_d = '0;
    cnt2_d = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (sh1_q[p].valid) begin
        sum2_d = sum2_d + SUM_W'(CONTRIB_W'(dur1_q[p]) << sh1_q[p].s1)
                        + SUM_W'(CONTRIB_W'(dur1_q[p]) << sh1_q[p].s2);
      end
      cnt2_d = cnt2_d + EC_W'(cls1_q[p] != CLS_NONE);
    end
  end

  // Snapshot handshake: v_o is high for the whole REPORT state; the consumer
  // pulses yumi_i to take it. dump_req_i is only accepted while dump_ready_o.
  vlt_state_e state_d, state_q;
  logic       dump_fire;

  always_comb begin
    state_d   = state_q;
    dump_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dump_req_i) begin
          dump_fire = 1'b1;
          state_d   = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (yumi_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [ACC_W-1:0]  acc_d, acc_q, vul_d, vul_q, acc_sum;
  logic [ADD_W-1:0]  acc_wide;
  logic              acc_ovf;
  logic              sat_d, sat_q, sat_snap_d, sat_snap_q, sat_sum;
  logic [CNT_W-1:0]  cnt_d, cnt_q, evt_d, evt_q, cnt_sum;
  logic [CADD_W-1:0] cnt_wide;

  // The snapshot sees the stage-2 sum of the dump edge, so events two edges old are in.
  always_comb begin
    acc_wide   = ADD_W'(acc_q) + ADD_W'(sum2_q);
    acc_ovf    = |acc_wide[ADD_W-1:ACC_W];
    acc_sum    = acc_ovf ? '1 : acc_wide[ACC_W-1:0];
    sat_sum    = sat_q | acc_ovf;
    cnt_wide   = CADD_W'(cnt_q) + CADD_W'(cnt2_q);
    cnt_sum    = cnt_wide[CNT_W] ? '1 : cnt_wide[CNT_W-1:0];
    acc_d      = dump_fire ? '0 : acc_sum;
    sat_d      = dump_fire ? 1'b0 : sat_sum;
    cnt_d      = dump_fire ? '0 : cnt_sum;
    vul_d      = dump_fire ? acc_sum : vul_q;
    sat_snap_d = dump_fire ? sat_sum : sat_snap_q;
    evt_d      = dump_fire ? cnt_sum : evt_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int p = 0; p < PORTS; p++) begin
        sh1_q[p]  <= '0;
        cls1_q[p] <= CLS_NONE;
        dur1_q[p] <= '0;
      end
      sum2_q     <= '0;
      cnt2_q     <= '0;
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
      vul_q      <= '0;
      sat_snap_q <= 1'b0;
      evt_q      <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        sh1_q[p]  <= sh1_d[p];
        cls1_q[p] <= cls1_d[p];
        dur1_q[p] <= dur1_d[p];
      end
      sum2_q     <= sum2_d;
      cnt2_q     <= cnt2_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      cnt_q      <= cnt_d;
      vul_q      <= vul_d;
      sat_snap_q <= sat_snap_d;
      evt_q      <= evt_d;
    end
  end

`ifdef VLT_SQ_CLASS_CNT_EN
  logic [EC_W-1:0]   cls2_d  [N_CLS], cls2_q  [N_CLS];
  logic [CNT_W-1:0]  ccnt_d  [N_CLS], ccnt_q  [N_CLS];
  logic [CNT_W-1:0]  csnap_d [N_CLS], csnap_q [N_CLS];
  logic [CNT_W-1:0]  csum    [N_CLS];
  logic [CADD_W-1:0] cwide   [N_CLS];

  always_comb begin
    for (int k = 0; k < N_CLS; k++) begin
      cls2_d[k] = '0;
      for (int p = 0; p < PORTS; p++) begin
        cls2_d[k] = cls2_d[k] + EC_W'(int'(cls1_q[p]) == k + 1);
      end
      cwide[k]   = CADD_W'(ccnt_q[k]) + CADD_W'(cls2_q[k]);
      csum[k]    = cwide[k][CNT_W] ? '1 : cwide[k][CNT_W-1:0];
      ccnt_d[k]  = dump_fire ? '0 : csum[k];
      csnap_d[k] = dump_fire ? csum[k] : csnap_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N_CLS; k++) begin
      if (reset_i) begin
        cls2_q[k]  <= '0;
        ccnt_q[k]  <= '0;
        csnap_q[k] <= '0;
      end else begin
        cls2_q[k]  <= cls2_d[k];
        ccnt_q[k]  <= ccnt_d[k];
        csnap_q[k] <= csnap_d[k];
      end
    end
  end

  for (genvar k = 0; k < N_CLS; k++) begin : g_cls_out
    assign class_cnt_o[k*CNT_W +: CNT_W] = csnap_q[k];
  end
`else
  assign class_cnt_o = '0;
`endif

  assign dump_ready_o = (state_q == ST_IDLE);
  assign v_o          = (state_q == ST_REPORT);
  assign vul_o        = vul_q;
  assign evt_cnt_o    = evt_q;
  assign sat_o        = sat_snap_q;
  assign state_o      = state_q;

endmodule
